// File: rtl/txn_ctrl_unit_mo.sv
// Multi-outstanding VLSU transaction control: queues segment requests, splits them into
// 4 KiB-safe AXI bursts, publishes per-burst control to the data path, retires in order.
module txn_ctrl_unit_mo #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned AxiDataWidth   = 128,
  parameter int unsigned Depth          = 4,
  parameter int unsigned BurstFifoDepth = 8,
  parameter int unsigned MaxBurstLen    = 256,
  parameter int unsigned BeatsWidth     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrWidth-1:0]  req_addr_i,
  input  logic [BeatsWidth-1:0] req_beats_i,
  input  logic                  req_is_load_i,
  input  logic                  req_final_i,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [AddrWidth-1:0]  ax_addr_o,
  output logic [7:0]            ax_len_o,
  output logic [2:0]            ax_size_o,
  output logic [1:0]            ax_burst_o,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  output logic                  dp_valid_o,
  output logic                  dp_is_load_o,
  output logic [7:0]            dp_rmn_beat_o,
  output logic                  dp_is_head_o,
  output logic                  dp_last_burst_o,
  output logic                  dp_final_o,
  input  logic                  update_i,
  output logic                  idle_o
);

  localparam int unsigned BeatBytes = AxiDataWidth / 8;
  localparam int unsigned BeatShift = $clog2(BeatBytes);
  localparam int unsigned QW        = $clog2(Depth);
  localparam int unsigned FW        = $clog2(BurstFifoDepth);
  localparam logic [AddrWidth-1:0] AddrMask = ~AddrWidth'(BeatBytes - 1);

  // request queue
  logic [AddrWidth-1:0]  q_addr   [Depth];
  logic [BeatsWidth-1:0] q_rmn    [Depth];
  logic [7:0]            q_issued [Depth];
  logic [7:0]            q_brcvd  [Depth];
  logic [Depth-1:0]      q_load, q_final, q_done, q_data_done;
  logic [QW:0]           enq_ptr, iss_ptr, deq_ptr;
  logic [QW-1:0]         enq_idx, iss_idx, deq_idx;

  // issued-burst FIFO
  logic                  f_load  [BurstFifoDepth];
  logic                  f_last  [BurstFifoDepth];
  logic                  f_final [BurstFifoDepth];
  logic [7:0]            f_rmn   [BurstFifoDepth];
  logic [QW-1:0]         f_idx   [BurstFifoDepth];
  logic [FW:0]           f_wr, f_rd;
  logic [FW-1:0]         f_wr_idx, f_rd_idx;
  logic                  head_started;

  logic q_full, q_empty, iss_pend, f_full, f_empty;
  logic issue_go, ax_hs, issue_last, dp_upd, dp_pop, load_retire_now, retire, b_hs;
  logic [31:0] rmn_p1, page_beats, beats;
  logic [QW:0] iss_off, enq_off;

  assign enq_idx  = enq_ptr[QW-1:0];
  assign iss_idx  = iss_ptr[QW-1:0];
  assign deq_idx  = deq_ptr[QW-1:0];
  assign f_wr_idx = f_wr[FW-1:0];
  assign f_rd_idx = f_rd[FW-1:0];

  assign q_full   = (enq_idx == deq_idx) && (enq_ptr[QW] != deq_ptr[QW]);
  assign q_empty  = (enq_ptr == deq_ptr);
  assign iss_pend = (iss_ptr != enq_ptr);
  assign f_full   = (f_wr_idx == f_rd_idx) && (f_wr[FW] != f_rd[FW]);
  assign f_empty  = (f_wr == f_rd);

  // Burst size limited by the remainder, the 4 KiB page end and MaxBurstLen.
  always_comb begin
    rmn_p1     = 32'(q_rmn[iss_idx]) + 32'd1;
    page_beats = (32'd4096 - 32'(q_addr[iss_idx][11:0])) >> BeatShift;
    beats      = rmn_p1;
    if (page_beats < beats) beats = page_beats;
    if (MaxBurstLen < beats) beats = MaxBurstLen;
    issue_last = (beats == rmn_p1);
  end

  assign issue_go   = iss_pend && !f_full;
  assign ar_valid_o = issue_go && q_load[iss_idx];
  assign aw_valid_o = issue_go && !q_load[iss_idx];
  assign ax_hs      = (ar_valid_o && ar_ready_i) || (aw_valid_o && aw_ready_i);
  assign ax_addr_o  = issue_go ? q_addr[iss_idx] : '0;
  assign ax_len_o   = issue_go ? 8'(beats - 32'd1) : '0;
  assign ax_size_o  = issue_go ? 3'(BeatShift) : '0;
  assign ax_burst_o = 2'b01;

  assign dp_valid_o      = !f_empty;
  assign dp_is_load_o    = dp_valid_o && f_load[f_rd_idx];
  assign dp_rmn_beat_o   = dp_valid_o ? f_rmn[f_rd_idx] : '0;
  assign dp_is_head_o    = dp_valid_o && !head_started;
  assign dp_last_burst_o = dp_valid_o && f_last[f_rd_idx];
  assign dp_final_o      = dp_last_burst_o && f_final[f_rd_idx];
  assign dp_upd          = update_i && dp_valid_o;
  assign dp_pop          = dp_upd && (f_rmn[f_rd_idx] == 8'd0);

  // A load whose data finishes while an older store still waits for B is only marked here.
  assign load_retire_now = dp_pop && f_load[f_rd_idx] && f_last[f_rd_idx]
                           && (f_idx[f_rd_idx] == deq_idx);
  assign b_ready_o = !q_empty && !q_load[deq_idx] && (q_brcvd[deq_idx] < q_issued[deq_idx]);
  assign b_hs      = b_valid_i && b_ready_o;
  assign retire    = !q_empty && (q_load[deq_idx]
                       ? (q_data_done[deq_idx] || load_retire_now)
                       : (q_done[deq_idx] && (q_brcvd[deq_idx] == q_issued[deq_idx])));

  assign req_ready_o = !q_full;
  assign idle_o      = q_empty && f_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enq_ptr      <= '0;
      iss_ptr      <= '0;
      deq_ptr      <= '0;
      f_wr         <= '0;
      f_rd         <= '0;
      head_started <= 1'b0;
      q_load       <= '0;
      q_final      <= '0;
      q_done       <= '0;
      q_data_done  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        q_addr[i]   <= '0;
        q_rmn[i]    <= '0;
        q_issued[i] <= '0;
        q_brcvd[i]  <= '0;
      end
      for (int unsigned i = 0; i < BurstFifoDepth; i++) begin
        f_load[i]  <= 1'b0;
        f_last[i]  <= 1'b0;
        f_final[i] <= 1'b0;
        f_rmn[i]   <= '0;
        f_idx[i]   <= '0;
      end
    end else begin
      if (req_valid_i && !q_full) begin
        q_addr[enq_idx]      <= req_addr_i & AddrMask;
        q_rmn[enq_idx]       <= req_beats_i;
        q_load[enq_idx]      <= req_is_load_i;
        q_final[enq_idx]     <= req_final_i;
        q_issued[enq_idx]    <= '0;
        q_brcvd[enq_idx]     <= '0;
        q_done[enq_idx]      <= 1'b0;
        q_data_done[enq_idx] <= 1'b0;
        enq_ptr              <= enq_ptr + 1'b1;
      end
      if (ax_hs) begin
        f_load[f_wr_idx]  <= q_load[iss_idx];
        f_last[f_wr_idx]  <= issue_last;
        f_final[f_wr_idx] <= q_final[iss_idx];
        f_rmn[f_wr_idx]   <= 8'(beats - 32'd1);
        f_idx[f_wr_idx]   <= iss_idx;
        f_wr              <= f_wr + 1'b1;
        q_issued[iss_idx] <= q_issued[iss_idx] + 8'd1;
        if (issue_last) begin
          q_done[iss_idx] <= 1'b1;
          iss_ptr         <= iss_ptr + 1'b1;
        end else begin
          q_addr[iss_idx] <= q_addr[iss_idx] + (AddrWidth'(beats) << BeatShift);
          q_rmn[iss_idx]  <= q_rmn[iss_idx] - BeatsWidth'(beats);
        end
      end
      if (dp_upd) begin
        if (dp_pop) begin
          f_rd         <= f_rd + 1'b1;
          head_started <= 1'b0;
          if (f_load[f_rd_idx] && f_last[f_rd_idx]) q_data_done[f_idx[f_rd_idx]] <= 1'b1;
        end else begin
          f_rmn[f_rd_idx] <= f_rmn[f_rd_idx] - 8'd1;
          head_started    <= 1'b1;
        end
      end
      if (b_hs) q_brcvd[deq_idx] <= q_brcvd[deq_idx] + 8'd1;
      if (retire) deq_ptr <= deq_ptr + 1'b1;
    end
  end

  assign iss_off = iss_ptr - deq_ptr;
  assign enq_off = enq_ptr - deq_ptr;

  a_ptr_order: assert property (@(posedge clk_i) disable iff (rst_i)
    (iss_off <= enq_off) && (enq_off <= (QW+1)'(Depth)));
  a_update_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    update_i |-> dp_valid_o);
  a_b_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    b_valid_i |-> !q_empty);
  a_rmn_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    ax_hs |-> (beats <= rmn_p1) && (beats != 32'd0));
  a_one_dir: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ar_valid_o && aw_valid_o));

endmodule

// File: tb/tb_txn_ctrl_unit_mo.sv
// Scoreboard bench for txn_ctrl_unit_mo: expected bursts are queued at stimulus time and
// compared by monitors on AR/AW handshakes and on the first beat of each data-path burst.
module tb_txn_ctrl_unit_mo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_load, req_final;
  logic [31:0] req_addr;
  logic [15:0] req_beats;
  logic        ar_valid, ar_ready, aw_valid, aw_ready;
  logic [31:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic        b_valid, b_ready;
  logic        dp_valid, dp_is_load, dp_is_head, dp_last, dp_final;
  logic [7:0]  dp_rmn;
  logic        update, idle;

  txn_ctrl_unit_mo #(
    .AddrWidth(32), .AxiDataWidth(128), .Depth(4),
    .BurstFifoDepth(8), .MaxBurstLen(256), .BeatsWidth(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_beats_i(req_beats),
    .req_is_load_i(req_load), .req_final_i(req_final),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .ax_addr_o(ax_addr), .ax_len_o(ax_len), .ax_size_o(ax_size), .ax_burst_o(ax_burst),
    .b_valid_i(b_valid), .b_ready_o(b_ready),
    .dp_valid_o(dp_valid), .dp_is_load_o(dp_is_load), .dp_rmn_beat_o(dp_rmn),
    .dp_is_head_o(dp_is_head), .dp_last_burst_o(dp_last), .dp_final_o(dp_final),
    .update_i(update), .idle_o(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic ld; logic [31:0] addr; logic [7:0] len;} ax_t;
  typedef struct packed {logic ld; logic [7:0] len; logic last; logic fin;} dp_t;

  ax_t ax_q[$];
  dp_t dp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  auto_dp = 1'b0;
  bit  auto_b  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_burst(input logic ld, input logic [31:0] a, input logic [7:0] len,
                           input logic last, input logic fin);
    ax_q.push_back('{ld: ld, addr: a, len: len});
    dp_q.push_back('{ld: ld, len: len, last: last, fin: fin});
  endtask

  // Monitors: sampled on the falling edge, the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if ((ar_valid && ar_ready) || (aw_valid && aw_ready)) begin
        if (ax_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ax_unexpected: got addr 0x%0h len %0d with nothing expected", ax_addr, ax_len);
        end else begin
          ax_t e;
          e = ax_q.pop_front();
          chk("ax_burst", {ar_valid, aw_valid, ax_addr, ax_len, ax_size, ax_burst},
                          {e.ld, !e.ld, e.addr, e.len, 3'd4, 2'b01});
        end
      end
      if (update && dp_valid && dp_is_head) begin
        if (dp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dp_unexpected: got rmn %0d with nothing expected", dp_rmn);
        end else begin
          dp_t d;
          d = dp_q.pop_front();
          chk("dp_head", {dp_is_load, dp_rmn, dp_last, dp_final}, {d.ld, d.len, d.last, d.fin});
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    update  = auto_dp && dp_valid;
    b_valid = auto_b && b_ready;
  endtask

  task automatic send(input logic [31:0] a, input logic [15:0] n, input logic ld, input logic fin);
    bit hs = 1'b0;
    req_addr = a; req_beats = n; req_load = ld; req_final = fin; req_valid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      hs = req_ready;
      cycle();
    end
    req_valid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no handshake for addr 0x%0h expected one", a);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && !idle; i++) cycle();
    chk(name, idle, 1);
  endtask

  initial begin
    req_valid = 0; req_addr = '0; req_beats = '0; req_load = 0; req_final = 0;
    ar_ready = 0; aw_ready = 0; b_valid = 0; update = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_outputs", {req_ready, idle, ar_valid, aw_valid, dp_valid, b_ready, ax_burst},
                       {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01});
    chk("rst_ax", {ax_addr, ax_len, ax_size}, '0);

    // Load crossing a 4 KiB page: two 4-beat bursts
    ar_ready = 1; aw_ready = 1; auto_dp = 1; auto_b = 1;
    exp_burst(1, 32'h0FC0, 8'd3, 0, 0);
    exp_burst(1, 32'h1000, 8'd3, 1, 0);
    send(32'h0FC0, 16'd7, 1, 0);
    wait_idle("load_split_idle", 100);

    // 512-beat store: two max-length bursts, retires only after both B responses
    auto_b = 0;
    exp_burst(0, 32'h0000, 8'd255, 0, 0);
    exp_burst(0, 32'h1000, 8'd255, 1, 0);
    send(32'h0000, 16'd511, 0, 0);
    for (int i = 0; i < 700 && (ax_q.size() != 0 || dp_valid); i++) cycle();
    chk("store_wait_b", {idle, b_ready}, {1'b0, 1'b1});
    b_valid = 1; cycle();
    chk("store_after_b1", {idle, b_ready}, {1'b0, 1'b1});
    b_valid = 1; cycle();
    chk("store_after_b2", {idle, b_ready}, {1'b0, 1'b0});
    cycle();
    chk("store_retired_idle", idle, 1);

    // Queue full / first retire reopens it, three rounds to wrap the pointers
    auto_b = 1;
    for (int r = 0; r < 3; r++) begin
      ar_ready = 0;
      for (int k = 0; k < 4; k++) begin
        exp_burst(1, 32'h0002_0000 + r * 32'h2000 + k * 32'h40, 8'(k), 1, 0);
        send(32'h0002_0000 + r * 32'h2000 + k * 32'h40, 16'(k), 1, 0);
      end
      chk("queue_full_ready", req_ready, 0);
      ar_ready = 1;
      cycle();
      chk("ready_before_retire", req_ready, 0);
      cycle();
      chk("ready_after_retire", req_ready, 1);
      wait_idle("fill_round_idle", 100);
    end

    // Burst FIFO full: 9 bursts pending, only 8 fit
    auto_dp = 0;
    for (int i = 0; i < 3; i++) begin
      exp_burst(1, 32'h0004_0FF0 + i * 32'h1_0000, 8'd0, 0, 0);
      exp_burst(1, 32'h0004_1000 + i * 32'h1_0000, 8'd255, 0, 0);
      exp_burst(1, 32'h0004_2000 + i * 32'h1_0000, 8'd0, 1, 0);
      send(32'h0004_0FF0 + i * 32'h1_0000, 16'd257, 1, 0);
    end
    repeat (15) cycle();
    chk("fifo_full_blocks_ar", {ar_valid, dp_valid}, {1'b0, 1'b1});
    update = 1;
    cycle();
    chk("ar_after_pop", ar_valid, 1);
    auto_dp = 1;
    wait_idle("fifo_full_idle", 1200);

    // Interleaved load/store/load, final on the last load
    exp_burst(1, 32'h3000, 8'd1, 1, 0);
    exp_burst(0, 32'h4000, 8'd2, 1, 0);
    exp_burst(1, 32'h5000, 8'd3, 1, 1);
    send(32'h3000, 16'd1, 1, 0);
    send(32'h4000, 16'd2, 0, 0);
    send(32'h5000, 16'd3, 1, 1);
    wait_idle("interleave_idle", 100);
    chk("interleave_b_ready", b_ready, 0);

    // Reset in the middle of a 4-beat burst
    auto_dp = 0;
    exp_burst(1, 32'h6000, 8'd3, 1, 0);
    send(32'h6000, 16'd3, 1, 0);
    for (int i = 0; i < 20 && !dp_valid; i++) cycle();
    update = 1; cycle();
    update = 1; cycle();
    chk("mid_burst_state", {dp_valid, dp_rmn, dp_is_head}, {1'b1, 8'd1, 1'b0});
    rst = 1'b1;
    cycle();
    chk("reset_mid_burst", {ar_valid, aw_valid, dp_valid, b_ready, req_ready, idle},
                           {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    rst = 1'b0;
    cycle();
    chk("ax_scoreboard_drained", ax_q.size(), 0);
    chk("dp_scoreboard_drained", dp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
